// File: rtl/lab4_pkg.sv
// rtl/lab4_pkg.sv - shared constants, scan state type and anode patterns for the BCD scan counter
package lab4_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } scan_state_t;

  localparam logic [3:0] ANODE_DIG0 = 4'b1110;
  localparam logic [3:0] ANODE_DIG1 = 4'b1101;
  localparam logic [3:0] ANODE_DIG2 = 4'b1011;
  localparam logic [3:0] ANODE_DIG3 = 4'b0111;

  function automatic logic [3:0] anode_pattern(input scan_state_t s);
    logic [3:0] a;
    case (s)
      DIG0:    a = ANODE_DIG0;
      DIG1:    a = ANODE_DIG1;
      DIG2:    a = ANODE_DIG2;
      DIG3:    a = ANODE_DIG3;
      default: a = ANODE_DIG0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one decade counter with inc/dec enables, carry/borrow out and synchronous load
module bcd_digit (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] digit,
  output logic       carry,
  output logic       borrow
);

  // Carry/borrow are combinational so a whole ripple settles within one cycle.
  assign carry  = inc && (digit >= 4'd9);
  assign borrow = dec && (digit == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= (load_digit > 4'd9) ? 4'd0 : load_digit;
    end else if (inc) begin
      digit <= (digit >= 4'd9) ? 4'd0 : digit + 4'd1;
    end else if (dec) begin
      digit <= (digit == 4'd0) ? 4'd9 : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - 4-digit BCD up/down counter with multiplexed 7-segment scan output
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant nonzero digit.
module bcd_scan_counter
  import lab4_pkg::*;
#(
  parameter int CNT_DIV  = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [3:0]  value,
  output logic [3:0]  anode,
  output logic [15:0] count,
  output logic        rollover
);

  localparam int CW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] presc;
  logic          tick;
  logic          step;

  assign tick = (presc == CW'(CNT_DIV - 1));
  // Load wins over counting, so a tick coinciding with load is dropped.
  assign step = en && tick && !load;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      presc <= '0;
    end else if (en) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  logic [3:0] d0, d1, d2, d3;
  logic       c0, c1, c2, c3;
  logic       b0, b1, b2, b3;

  bcd_digit u_dig0 (
    .clk(clk), .reset(reset), .load(load), .load_digit(load_val[3:0]),
    .inc(step && up), .dec(step && !up), .digit(d0), .carry(c0), .borrow(b0)
  );
  bcd_digit u_dig1 (
    .clk(clk), .reset(reset), .load(load), .load_digit(load_val[7:4]),
    .inc(c0), .dec(b0), .digit(d1), .carry(c1), .borrow(b1)
  );
  bcd_digit u_dig2 (
    .clk(clk), .reset(reset), .load(load), .load_digit(load_val[11:8]),
    .inc(c1), .dec(b1), .digit(d2), .carry(c2), .borrow(b2)
  );
  bcd_digit u_dig3 (
    .clk(clk), .reset(reset), .load(load), .load_digit(load_val[15:12]),
    .inc(c2), .dec(b2), .digit(d3), .carry(c3), .borrow(b3)
  );

  assign count = {d3, d2, d1, d0};

  // A carry or borrow out of the top digit is exactly a full-range wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      rollover <= 1'b0;
    end else begin
      rollover <= c3 || b3;
    end
  end

  logic [SW-1:0] scan_cnt;
  logic          scan_adv;
  scan_state_t   state_q, state_d;

  assign scan_adv = (scan_cnt == SW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      state_q  <= DIG0;
    end else begin
      scan_cnt <= scan_adv ? '0 : scan_cnt + 1'b1;
      state_q  <= state_d;
    end
  end

  logic [3:0] raw_digit;
  logic       blank;

  always_comb begin
    state_d   = state_q;
    raw_digit = d0;
    blank     = 1'b0;
    case (state_q)
      DIG0: begin
        raw_digit = d0;
        if (scan_adv) state_d = DIG1;
      end
      DIG1: begin
        raw_digit = d1;
        blank     = (count[15:4] == 12'd0);
        if (scan_adv) state_d = DIG2;
      end
      DIG2: begin
        raw_digit = d2;
        blank     = (count[15:8] == 8'd0);
        if (scan_adv) state_d = DIG3;
      end
      DIG3: begin
        raw_digit = d3;
        blank     = (count[15:12] == 4'd0);
        if (scan_adv) state_d = DIG0;
      end
      default: state_d = DIG0;
    endcase
  end

  assign anode = anode_pattern(state_q);

`ifdef LEADING_ZERO_BLANK_EN
  assign value = blank ? BLANK_CODE : raw_digit;
`else
  logic unused_blank;
  assign unused_blank = blank;
  assign value        = raw_digit;
`endif

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb/tb_bcd_scan_counter.sv - scoreboard bench for bcd_scan_counter with CNT_DIV=2, SCAN_DIV=1
module tb_bcd_scan_counter;

  logic        clk = 1'b0;
  logic        reset, en, up, load;
  logic [15:0] load_val;
  logic [3:0]  value, anode;
  logic [15:0] count;
  logic        rollover;

  localparam int K_COUNT = 0;
  localparam int K_ANODE = 1;
  localparam int K_VALUE = 2;
  localparam int K_ROLL  = 3;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [15:0] THOU_VAL = 16'h000F;
`else
  localparam logic [15:0] THOU_VAL = 16'h0000;
`endif

  bcd_scan_counter #(.CNT_DIV(2), .SCAN_DIV(1)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .value(value), .anode(anode),
    .count(count), .rollover(rollover)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] expv;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic [15:0] act;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int kind, input logic [15:0] v, input string name);
    exp_t e;
    e.due  = cyc;
    e.kind = kind;
    e.expv = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops every expectation due in the current cycle, away from the edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      case (cur.kind)
        K_COUNT: act = count;
        K_ANODE: act = {12'd0, anode};
        K_VALUE: act = {12'd0, value};
        default: act = {15'd0, rollover};
      endcase
      checks++;
      if (cur.due != cyc) begin
        failures++;
        $display("FAIL %s: expectation stale (due %0d, now %0d)", cur.name, cur.due, cyc);
      end else if (act !== cur.expv) begin
        failures++;
        $display("FAIL %s: got %h want %h", cur.name, act, cur.expv);
      end
    end
  end

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 16'h0000;
    step(2);
    push(K_COUNT, 16'h0000, "reset_count");
    push(K_ANODE, 16'h000E, "reset_anode");
    push(K_VALUE, 16'h0000, "reset_value");
    push(K_ROLL,  16'h0000, "reset_roll");

    reset = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      push(K_ROLL, 16'h0000, "up20_no_roll");
    end
    push(K_COUNT, 16'h0010, "up20_count");

    en = 1'b0;
    step(4);
    push(K_COUNT, 16'h0010, "en_low_hold");

    en = 1'b1; up = 1'b1; load = 1'b1; load_val = 16'h9998;
    step(1);
    load = 1'b0;
    push(K_COUNT, 16'h9998, "load9998");
    push(K_ROLL,  16'h0000, "load9998_roll");
    step(1); push(K_COUNT, 16'h9998, "up_a");    push(K_ROLL, 16'h0000, "up_a_roll");
    step(1); push(K_COUNT, 16'h9999, "up_9999"); push(K_ROLL, 16'h0000, "up_9999_roll");
    step(1); push(K_COUNT, 16'h9999, "up_b");    push(K_ROLL, 16'h0000, "up_b_roll");
    step(1); push(K_COUNT, 16'h0000, "up_wrap"); push(K_ROLL, 16'h0001, "up_wrap_roll");
    step(1); push(K_COUNT, 16'h0000, "up_post"); push(K_ROLL, 16'h0000, "up_post_roll");

    up = 1'b0; load = 1'b1; load_val = 16'h0000;
    step(1);
    load = 1'b0;
    push(K_COUNT, 16'h0000, "load0000"); push(K_ROLL, 16'h0000, "load0000_roll");
    step(1); push(K_COUNT, 16'h0000, "dn_a");    push(K_ROLL, 16'h0000, "dn_a_roll");
    step(1); push(K_COUNT, 16'h9999, "dn_wrap"); push(K_ROLL, 16'h0001, "dn_wrap_roll");
    step(1); push(K_COUNT, 16'h9999, "dn_post"); push(K_ROLL, 16'h0000, "dn_post_roll");

    load = 1'b1; load_val = 16'h12A4;
    step(1);
    load = 1'b0;
    push(K_COUNT, 16'h1204, "load12A4");
    step(1);
    push(K_COUNT, 16'h1204, "pre_tick");
    up = 1'b1; load = 1'b1; load_val = 16'h0777;
    step(1);
    load = 1'b0;
    push(K_COUNT, 16'h0777, "load_vs_tick"); push(K_ROLL, 16'h0000, "load_vs_tick_roll");
    step(1); push(K_COUNT, 16'h0777, "presc_cleared");
    step(1); push(K_COUNT, 16'h0778, "after_load_tick");

    en = 1'b0; load = 1'b1; load_val = 16'hFA9B;
    step(1);
    load = 1'b0;
    push(K_COUNT, 16'h0090, "nibble_clamp");

    reset = 1'b1;
    step(1);
    reset = 1'b0;
    push(K_ANODE, 16'h000E, "scan_reset_anode");
    push(K_VALUE, 16'h0000, "scan_reset_value");
    load = 1'b1; load_val = 16'h0305;
    step(1);
    load = 1'b0;
    push(K_COUNT, 16'h0305, "scan_count");
    push(K_ANODE, 16'h000D, "scan_an1"); push(K_VALUE, 16'h0000, "scan_val1");
    step(1); push(K_ANODE, 16'h000B, "scan_an2"); push(K_VALUE, 16'h0003, "scan_val2");
    step(1); push(K_ANODE, 16'h0007, "scan_an3"); push(K_VALUE, THOU_VAL, "scan_val3");
    step(1); push(K_ANODE, 16'h000E, "scan_an0"); push(K_VALUE, 16'h0005, "scan_val0");
    step(1); push(K_ANODE, 16'h000D, "scan_an1b"); push(K_VALUE, 16'h0000, "scan_val1b");

    reset = 1'b1;
    step(1);
    reset = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 16'h0457;
    step(1);
    load = 1'b0;
    step(1);
    push(K_COUNT, 16'h0457, "mid_count");
    push(K_ANODE, 16'h000B, "mid_anode");
    push(K_VALUE, 16'h0004, "mid_value");
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    push(K_COUNT, 16'h0000, "midrst_count");
    push(K_ANODE, 16'h000E, "midrst_anode");
    push(K_VALUE, 16'h0000, "midrst_value");
    push(K_ROLL,  16'h0000, "midrst_roll");
    step(2);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
